seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 185 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with BCD decode, leading-zero
// blanking, per-slot anti-ghosting blanking and a tear-free load path.
// A write lands in a shadow register and is copied to the display register
// only on the slot-3 -> slot-0 wrap, so a frame never mixes old and new data.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 20000,
  parameter int unsigned BLANK_CYC   = 200,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic        ready,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CntBlank = CW'(BLANK_CYC);

  typedef enum logic {
    StIdle,
    StPend
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [15:0]   shadow_bcd_q;
  logic [3:0]    shadow_dp_q;
  logic [15:0]   disp_bcd_q;
  logic [3:0]    disp_dp_q;

  logic          cnt_last;
  logic          wrap;
  logic          in_blank;
  logic [3:0]    cur_digit;
  logic          cur_dp;
  logic          cur_lz;
  logic [3:0]    cur_an;
  logic          lz3;
  logic          lz2;
  logic          lz1;

  // abcdefg, active-low; non-BCD nibbles are dark
  function automatic logic [6:0] seg7_decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign cnt_last = (cnt_q == CntLast);
  assign wrap     = cnt_last && (idx_q == 2'd3);
  assign in_blank = (BLANK_CYC != 0) && (cnt_q < CntBlank);

  // Leading-zero chain runs from the most significant digit downwards
  assign lz3 = BLANK_LZ && (disp_bcd_q[15:12] == 4'd0);
  assign lz2 = lz3 && (disp_bcd_q[11:8] == 4'd0);
  assign lz1 = lz2 && (disp_bcd_q[7:4] == 4'd0);

  // Refresh counter and slot index; index advances each time the count rolls over
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (cnt_last) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Transfer FSM: capture into shadow on accept, commit to display on frame wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ready        <= 1'b1;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // Accept on a wrap cycle still leaves the display alone until the next wrap
          if (load && ready) begin
            shadow_bcd_q <= bcd_in;
            shadow_dp_q  <= dp_in;
            state_q      <= StPend;
            ready        <= 1'b0;
          end
        end
        StPend: begin
          if (wrap) begin
            disp_bcd_q <= shadow_bcd_q;
            disp_dp_q  <= shadow_dp_q;
            state_q    <= StIdle;
            ready      <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          ready   <= 1'b1;
        end
      endcase
    end
  end

  // Select the digit, decimal point, blanking flag and anode for the active slot
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    cur_an    = 4'b1111;
    unique case (idx_q)
      2'd0: begin
        cur_digit = disp_bcd_q[3:0];
        cur_dp    = disp_dp_q[0];
        cur_lz    = 1'b0;
        cur_an    = 4'b1110;
      end
      2'd1: begin
        cur_digit = disp_bcd_q[7:4];
        cur_dp    = disp_dp_q[1];
        cur_lz    = lz1;
        cur_an    = 4'b1101;
      end
      2'd2: begin
        cur_digit = disp_bcd_q[11:8];
        cur_dp    = disp_dp_q[2];
        cur_lz    = lz2;
        cur_an    = 4'b1011;
      end
      2'd3: begin
        cur_digit = disp_bcd_q[15:12];
        cur_dp    = disp_dp_q[3];
        cur_lz    = lz3;
        cur_an    = 4'b0111;
      end
      default: begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        cur_an    = 4'b1111;
      end
    endcase
  end

  // Registered drive outputs, one clock behind the count/index they are derived from
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (in_blank) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= cur_an;
      seg <= cur_lz ? 7'b1111111 : seg7_decode(cur_digit);
      // Decimal point is independent of zero blanking
      dp  <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at REFRESH_DIV=8, BLANK_CYC=2.
// 'edges' counts clock edges since reset release; outputs sampled on the
// falling edge after edge k reflect frame position k-1.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_checks;
  int n_fail;
  int edges;

  seg7_scan_driver #(
    .REFRESH_DIV(8),
    .BLANK_CYC  (2),
    .BLANK_LZ   (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bcd_in(bcd_in),
    .dp_in (dp_in),
    .load  (load),
    .ready (ready),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  // Advance at least one falling edge, stopping when edges%32 == target
  task automatic wait_pos(input int target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (((edges % 32) != target) && (guard < 40));
    if ((edges % 32) != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pos: position %0d, required %0d", edges % 32, target);
    end
  endtask

  // Present one load strobe for a single clock (accepted on the next rising edge)
  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Check one full 32-cycle frame starting at the next frame-position-0 sample
  task automatic check_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpm);
    logic [6:0] sx [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         slot;
    int         pos;
    sx[0] = s0;
    sx[1] = s1;
    sx[2] = s2;
    sx[3] = s3;
    wait_pos(1);
    for (int i = 0; i < 32; i++) begin
      if (i != 0) @(negedge clk);
      slot = i / 8;
      pos  = i % 8;
      if (pos < 2) begin
        exp_an  = 4'b1111;
        exp_seg = 7'b1111111;
        exp_dp  = 1'b1;
      end else begin
        exp_an  = ~(4'b0001 << slot);
        exp_seg = sx[slot];
        exp_dp  = ~dpm[slot];
      end
      n_checks++;
      if (an !== exp_an) begin
        n_fail++;
        $display("FAIL %s an @%0d: got %b, required %b", name, i, an, exp_an);
      end
      n_checks++;
      if (seg !== exp_seg) begin
        n_fail++;
        $display("FAIL %s seg @%0d: got %b, required %b", name, i, seg, exp_seg);
      end
      n_checks++;
      if (dp !== exp_dp) begin
        n_fail++;
        $display("FAIL %s dp @%0d: got %b, required %b", name, i, dp, exp_dp);
      end
    end
  endtask

  task automatic test_reset;
    rst    = 1'b0;
    bcd_in = 16'h0000;
    dp_in  = 4'b0000;
    load   = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if ({an, seg, dp, ready} !== {4'b1111, 7'b1111111, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got an=%b seg=%b dp=%b ready=%b, required 1111 1111111 1 1",
               an, seg, dp, ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_frame("reset_frame", 7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111, 4'b0000);
  endtask

  task automatic test_load;
    wait_pos(5);
    do_load(16'h0907, 4'b0010);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ready_fall: got %b, required 0", ready);
    end
    wait_pos(31);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ready_pend: got %b, required 0", ready);
    end
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_ready_commit: got %b, required 1", ready);
    end
    check_frame("load_0907", 7'b0001111, 7'b0000001, 7'b0000100, 7'b1111111, 4'b0010);
  endtask

  task automatic test_ignore_pend;
    wait_pos(10);
    do_load(16'h0123, 4'b0000);
    bcd_in = 16'h1111;
    dp_in  = 4'b1111;
    load   = 1'b1;
    repeat (3) @(negedge clk);
    load   = 1'b0;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_ready: got %b, required 0", ready);
    end
    wait_pos(31);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_ready_commit: got %b, required 1", ready);
    end
    check_frame("ignore_0123", 7'b0000110, 7'b0010010, 7'b1001111, 7'b1111111, 4'b0000);
  endtask

  task automatic test_wrap_load;
    wait_pos(31);
    do_load(16'h5678, 4'b1000);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_ready_fall: got %b, required 0", ready);
    end
    // Frame after the accepting wrap must still show the old value
    check_frame("wrap_old", 7'b0000110, 7'b0010010, 7'b1001111, 7'b1111111, 4'b0000);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_ready_commit: got %b, required 1", ready);
    end
    check_frame("wrap_new", 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100, 4'b1000);
  endtask

  task automatic test_invalid;
    wait_pos(3);
    do_load(16'h00AF, 4'b0001);
    wait_pos(31);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_ready_commit: got %b, required 1", ready);
    end
    check_frame("invalid_00af", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 4'b0001);
  endtask

  task automatic test_reset_mid_pend;
    wait_pos(4);
    do_load(16'h2222, 4'b1111);
    wait_pos(20);
    n_checks++;
    if (an !== 4'b1011) begin
      n_fail++;
      $display("FAIL midrst_pre_an: got %b, required 1011", an);
    end
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pre_ready: got %b, required 0", ready);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({an, seg, dp, ready} !== {4'b1111, 7'b1111111, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_async: got an=%b seg=%b dp=%b ready=%b, required 1111 1111111 1 1",
               an, seg, dp, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    check_frame("midrst_frame", 7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111, 4'b0000);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b, required 1", ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_load();
    test_ignore_pend();
    test_wrap_load();
    test_invalid();
    test_reset_mid_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
